// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that launches words into a UART transmitter over its enable/busy handshake (optional flush via UART_TX_FIFO_FLUSH_EN)
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    o_busy,
`ifdef UART_TX_FIFO_FLUSH_EN
  input  logic                    flush,
`endif
  output logic                    enable,
  output logic [DATA_WIDTH-1:0]   i_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, BUSY = 2'd2, GAP = 2'd3;
  logic [1:0] state, state_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt_nx;
  logic push, pop, pop_d, clr;
`ifdef UART_TX_FIFO_FLUSH_EN
  logic flush_pend;
  assign clr = (flush || flush_pend) && (state == IDLE || state == GAP || (state == BUSY && !o_busy));
  // a flush seen mid-frame is held until the frame finishes and BUSY hands over to GAP
  always_ff @(posedge clk or posedge reset)
    if (reset) flush_pend <= 1'b0;
    else flush_pend <= clr ? 1'b0 : (flush_pend || flush);
`else
  assign clr = 1'b0;
`endif
  assign push = wr_en && !full && !clr;
  assign pop = state == IDLE && !empty && !o_busy && !clr;
  assign cnt_nx = count + (AW+1)'(push) - (AW+1)'(pop_d);
  // next state of the launch sequencer
  always_comb
    state_nx = (state == IDLE)   ? (pop ? LAUNCH : IDLE) :
               (state == LAUNCH) ? (o_busy ? BUSY : LAUNCH) :
               (state == BUSY)   ? (o_busy ? BUSY : GAP) : IDLE;
  // storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  // pointers and occupancy; a pop is counted one cycle after it launches
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      overflow <= 1'b0;
      pop_d <= 1'b0;
    end else begin
      overflow <= wr_en && full && !clr;
      pop_d <= pop;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        empty <= 1'b1;
        full <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= cnt_nx;
        empty <= cnt_nx == '0;
        full <= cnt_nx == (AW+1)'(DEPTH);
      end
    end
  // launch handshake; i_data is only reloaded on a pop so it stays stable for the whole frame
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      enable <= 1'b0;
      i_data <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        enable <= 1'b1;
        i_data <= mem[rd_ptr];
      end else if (state == LAUNCH && o_busy) enable <= 1'b0;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized scoreboard bench for uart_tx_fifo with a behavioural UART and occupancy model
module tb_uart_tx_fifo;
  localparam int DW = 8, DEPTH = 16, CW = $clog2(DEPTH) + 1;
  logic clk = 0, reset = 1, wr_en = 0, o_busy = 0, flush = 0;
  logic [DW-1:0] wr_data = '0;
  logic full, empty, overflow, enable;
  logic [DW-1:0] i_data;
  logic [CW-1:0] count;
  int tests = 0, errs = 0;
  logic [DW-1:0] exp_q[$];
  int mcnt = 0, rises = 0, ucnt = 0, r0;
  bit rose_prev = 0, prev_en = 0, chk = 1, hold = 0, ust = 0, m_acc, m_ovf, m_rose;
  logic [DW-1:0] last_i = '0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .o_busy(o_busy),
`ifdef UART_TX_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .enable(enable), .i_data(i_data));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // UART model: answers a launch with busy after a random latency and holds it a random time
  initial forever begin
    @(negedge clk);
    if (reset) begin o_busy = 0; ust = 0; ucnt = 0; end
    else if (hold) o_busy = 1;
    else if (o_busy) begin
      if (ucnt == 0) o_busy = 0; else ucnt--;
    end else if (ust) begin
      if (ucnt == 0) begin o_busy = 1; ucnt = $urandom_range(0, 5); ust = 0; end
      else ucnt--;
    end else if (enable) begin ust = 1; ucnt = $urandom_range(0, 3); end
  end

  // monitor: occupancy model, launch scoreboard and handshake invariants
  initial forever begin
    @(posedge clk); #1;
    if (reset) begin
      exp_q.delete(); mcnt = 0; rose_prev = 0; prev_en = 0; last_i = '0;
    end else begin
      m_ovf = wr_en && mcnt == DEPTH;
      m_acc = wr_en && mcnt < DEPTH && chk;
      if (m_acc) exp_q.push_back(wr_data);
      mcnt = chk ? mcnt + int'(m_acc) - int'(rose_prev) : 0;
      if (chk) begin
        check("count", count, mcnt);
        check("full", full, mcnt == DEPTH);
        check("empty", empty, mcnt == 0);
        check("overflow", overflow, m_ovf);
      end
      check("enable_while_busy", enable && o_busy, 0);
      m_rose = enable && !prev_en;
      if (m_rose) begin
        rises++;
        if (exp_q.size() == 0) check("unexpected_launch", 1, 0);
        else check("launch_data", i_data, exp_q.pop_front());
      end else check("i_data_hold", i_data, last_i);
      prev_en = enable; rose_prev = m_rose; last_i = i_data;
    end
  end

  task automatic wait_drain(input int bound);
    int k = 0;
    while (k < bound && !(exp_q.size() == 0 && count == 0 && !enable && !o_busy)) begin
      @(negedge clk); k++;
    end
    check("drain_in_time", k < bound, 1);
  endtask

  task automatic wait_busy(input int bound);
    int k = 0;
    while (k < bound && !o_busy) begin @(negedge clk); k++; end
    check("busy_in_time", k < bound, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, g;
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_enable", enable, 0);
    check("rst_i_data", i_data, 0);
    check("rst_overflow", overflow, 0);
    reset = 0;
    repeat (5) @(negedge clk);
    wr_en = 1; wr_data = 8'hA5;
    @(negedge clk); wr_en = 0;
    check("single_count", count, 1);
    @(negedge clk);
    check("single_enable", enable, 1);
    check("single_data", i_data, 8'hA5);
    @(negedge clk);
    check("single_empty", empty, 1);
    wait_drain(200);
    hold = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      wr_en = 1; wr_data = 8'(i + 1);
      @(negedge clk);
      if (i == 15) check("burst_full", full, 1);
      if (i == 16) check("burst_overflow", overflow, 1);
    end
    wr_en = 0;
    r0 = rises;
    hold = 0;
    wait_drain(2000);
    check("burst_launches", rises - r0, 16);
    for (int i = 0; i < 400; i++) begin
      wr_en = $urandom_range(0, 3) == 0;
      wr_data = 8'($urandom);
      @(negedge clk);
    end
    wr_en = 0;
    wait_drain(2000);
    n = 0; g = 0;
    while (n < 40 && g < 3000) begin
      wr_en = count < 2;
      wr_data = 8'(8'h40 + n);
      if (wr_en) n++;
      @(negedge clk);
      check("wrap_max_count", count <= 3, 1);
      g++;
    end
    wr_en = 0;
    check("wrap_words", n, 40);
    wait_drain(2000);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_data = 8'(8'hC0 + i);
      @(negedge clk);
    end
    wr_en = 0;
    wait_busy(50);
    @(posedge clk); #3;
    reset = 1; #1;
    check("midrst_enable", enable, 0);
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    repeat (2) @(negedge clk);
    reset = 0;
    r0 = rises;
    repeat (30) @(negedge clk);
    check("midrst_no_launch", rises - r0, 0);
`ifdef UART_TX_FIFO_FLUSH_EN
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_data = 8'(8'hF0 + i);
      @(negedge clk);
    end
    wr_en = 0;
    wait_busy(50);
    chk = 0; exp_q.delete(); flush = 1;
    @(negedge clk); flush = 0;
    r0 = rises;
    repeat (30) @(negedge clk);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_no_launch", rises - r0, 0);
    chk = 1;
    repeat (3) @(negedge clk);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch sequencer sitting directly upstream of the UART transmitter. Host logic pushes bytes with a single-cycle write strobe at any rate. The block drains them one at a time into the transmitter's `enable`/`i_data` inputs, obeying the transmitter's busy handshake. Data words are held stable for the entire frame, so the transmitter can sample them at its own baud tick.

## Interface
- `DATA_WIDTH`, 8, width of each buffered word; matches the transmitter's `INPUT_DATA_WIDTH`.
- `DEPTH`, 16, number of FIFO entries; must be a power of two, ≥2.
- `clk` input 1: single clock for the whole block.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `wr_en` input 1: push strobe; one word per cycle.
- `wr_data` input DATA_WIDTH: word pushed when `wr_en`=1.
- `full` output 1: FIFO holds DEPTH words.
- `empty` output 1: FIFO holds 0 words.
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` output 1: one-cycle pulse when a push is dropped.
- `o_busy` input 1: transmitter busy, from UART.
- `enable` output 1: launch request to UART.
- `i_data` output DATA_WIDTH: word to UART.
- `flush` input 1: present only with `UART_TX_FIFO_FLUSH_EN`.

## Operation
- Storage: register array of DEPTH words, read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and an occupancy counter.
- Push: `wr_en` && !`full` writes `wr_data` at the write pointer and increments the write pointer.
- Overflow: `wr_en` && `full` drops the word; `overflow`=1 on the next cycle; FIFO contents unchanged.
- Pop: occurs only on the IDLE→LAUNCH transition. `i_data` <= head word, read pointer increments.
- Simultaneous push and pop: both take effect and `count` is unchanged. A push into a full FIFO in the same cycle as a pop is still dropped, because `full` is evaluated before the pop.
- FSM states:
  - IDLE: if !`empty` && !`o_busy`, pop and go to LAUNCH.
  - LAUNCH: `enable`=1; stay until `o_busy`=1 is sampled, then `enable`<=0 and go to BUSY.
  - BUSY: stay while `o_busy`=1; on `o_busy`=0 go to GAP.
  - GAP: one cycle, then IDLE. This guarantees `enable` never reasserts in the cycle the transmitter drops busy.
- `enable` is never 1 while in BUSY or GAP, and never 1 while `o_busy`=1 except the single cycle in which busy is first observed.
- `i_data` changes only on a pop. It holds its value from LAUNCH through GAP and beyond, until the next pop.
- Reset values: `enable`=0, `i_data`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, both pointers 0, state IDLE.
- Reset mid-frame aborts the frame and discards all buffered words. The UART shares the same reset.

## Timing
- All outputs are registered.
- `full`, `empty` and `count` update one cycle after the push or pop that changes them.
- Write into an empty, idle FIFO at cycle N (`wr_en`=1):
  - `count`=1 at N+1.
  - `enable`=1 with `i_data`=word at N+2.
  - `count`=0 at N+3 if there is no further push.
- Back-to-back frames: the next `enable` rises no earlier than 2 cycles after `o_busy` is sampled low (GAP, then IDLE pop).
- LAUNCH has no timeout. `enable` stays high until the UART raises `o_busy`, which is up to one baud period of `clk` cycles.

## Configuration
- `UART_TX_FIFO_FLUSH_EN` defined:
  - Adds the `flush` input.
  - `flush`=1 in IDLE or GAP resets both pointers and `count` to 0 on the next edge; pushes in that cycle are discarded.
  - `flush` in LAUNCH or BUSY is deferred: the flush is latched and applied on entry to GAP. The frame in flight completes.
- Not defined: no `flush` port; the FIFO empties only by draining.

## Test plan
- Single byte: reset, push 0xA5 at cycle 10 → `enable`=1 with `i_data`=0xA5 at cycle 12; `enable` drops the cycle after `o_busy` is sampled high; `empty`=1 at 13.
- Burst: push 0x01..0x10 (16 words) on consecutive cycles → `full`=1; a 17th push gives an `overflow` pulse; UART receives 0x01..0x10 in order; exactly 16 `enable` assertions.
- Stability: during every frame, `i_data` is constant from `enable` rise until `o_busy` falls; `enable`=0 whenever state is BUSY or GAP.
- Wrap and simultaneous push/pop: keep occupancy between 1 and 3 for 40 words → pointers wrap twice; `count` never exceeds 3; order is preserved.
- Reset mid-frame: 4 words queued, assert `reset` while `o_busy`=1 → same cycle `enable`=0, `count`=0, `empty`=1; no launch follows after reset release until a new push.
- With `UART_TX_FIFO_FLUSH_EN`: 5 words queued, `flush` during BUSY → the current frame finishes, `count`=0 after GAP, no further `enable`.
